// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: blanking codes,
// digit count, slot states and the active-low hex segment table.
package seg_pkg;

  localparam int NDIG = 8;
  localparam int DW   = $clog2(NDIG);

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_SHOW  = 1'b1
  } slot_e;

  // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with a pending
// buffer that is promoted to the displayed set only at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        LD,
  input  logic [31:0] DATA,
  input  logic [7:0]  EN,
  input  logic [7:0]  DP,
  output logic [7:0]  AN,
  output logic [7:0]  Ca,
  output logic        PEND,
  output logic        FRAME
);

  localparam int            CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [DW-1:0] DIG_MAX   = DW'(NDIG - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [31:0]   pdata_q, pdata_d, sdata_q, sdata_d;
  logic [7:0]    pen_q, pen_d, pdp_q, pdp_d;
  logic [7:0]    sen_q, sen_d, sdp_q, sdp_d;
  logic          pend_q, pend_d;
  logic [7:0]    an_q, an_d, ca_q, ca_d;
  logic          frame_q, frame_d;

  logic          wrap_s;
  logic [3:0]    nib_s;
  logic [6:0]    seg_s;
  slot_e         slot_s;

  assign wrap_s = (dig_q == DIG_MAX) && (cnt_q == CNT_MAX);
  assign nib_s  = sdata_q[{dig_q, 2'b00} +: 4];
  assign slot_s = (cnt_q < BLANK_END) ? SLOT_BLANK : SLOT_SHOW;

  seg_decode u_decode (
    .nib_i (nib_s),
    .seg_o (seg_s)
  );

  // Slot counter and digit index
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    dig_d = dig_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      dig_d = dig_q + DW'(1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Double buffer: shadow takes the old pending set at W before LD can overwrite it
  always_comb begin
    pdata_d = pdata_q;
    pen_d   = pen_q;
    pdp_d   = pdp_q;
    pend_d  = pend_q;
    sdata_d = sdata_q;
    sen_d   = sen_q;
    sdp_d   = sdp_q;
    if (wrap_s && pend_q) begin
      sdata_d = pdata_q;
      sen_d   = pen_q;
      sdp_d   = pdp_q;
    end else begin
      sdata_d = sdata_q;
    end
    if (LD) begin
      pdata_d = DATA;
      pen_d   = EN;
      pdp_d   = DP;
      pend_d  = 1'b1;
    end else if (wrap_s) begin
      pend_d  = 1'b0;
    end else begin
      pend_d  = pend_q;
    end
  end

  // Anode/cathode drive for the current slot, registered below
  always_comb begin
    an_d    = AN_OFF;
    ca_d    = SEG_OFF;
    frame_d = wrap_s;
    case (slot_s)
      SLOT_SHOW: begin
        if (sen_q[dig_q]) begin
          an_d = ~(8'd1 << dig_q);
          ca_d = {~sdp_q[dig_q], seg_s};
        end else begin
          an_d = AN_OFF;
          ca_d = SEG_OFF;
        end
      end
      SLOT_BLANK: begin
        an_d = AN_OFF;
        ca_d = SEG_OFF;
      end
      default: begin
        an_d = AN_OFF;
        ca_d = SEG_OFF;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      dig_q   <= '0;
      pdata_q <= 32'h0;
      pen_q   <= 8'h00;
      pdp_q   <= 8'h00;
      pend_q  <= 1'b0;
      sdata_q <= 32'h0;
      sen_q   <= 8'h00;
      sdp_q   <= 8'h00;
      an_q    <= AN_OFF;
      ca_q    <= SEG_OFF;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      pdata_q <= pdata_d;
      pen_q   <= pen_d;
      pdp_q   <= pdp_d;
      pend_q  <= pend_d;
      sdata_q <= sdata_d;
      sen_q   <= sen_d;
      sdp_q   <= sdp_d;
      an_q    <= an_d;
      ca_q    <= ca_d;
      frame_q <= frame_d;
    end
  end

  assign AN    = an_q;
  assign Ca    = ca_q;
  assign PEND  = pend_q;
  assign FRAME = frame_q;

endmodule
